// File: rtl/sram_pipe.sv
// sram_pipe: single-port SRAM model with a valid/ready request port, byte-masked
// write-through, a 1- or 2-cycle read pipeline and a credit-gated response FIFO.
// After reset (or an idle clr_start) the array is swept to zero one word per cycle.
module sram_pipe #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16384,
  parameter int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int READ_LAT  = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic              CK,
  input  logic              RSTN,
  input  logic              clr_start,
  output logic              init_done,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W/8-1:0] req_web,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata
);

  localparam int NB = DATA_W / 8;
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [CW-1:0]       cnt;
  logic                accept, pop, in_range;
  logic [DATA_W-1:0]   old_word, mrg_word;
  logic                push_vld;
  logic [DATA_W-1:0]   push_dat;

  logic [DATA_W-1:0]   mem  [DEPTH];
  logic [DATA_W-1:0]   fifo [RSP_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       fifo_cnt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == RSP_DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  assign init_done = (state_q == RUN);
  assign rsp_valid = (fifo_cnt != '0);
  assign rsp_rdata = rsp_valid ? fifo[rd_ptr] : '0;
  assign pop       = rsp_valid && rsp_ready;
  // A pop frees a credit in the same cycle, so a full block still accepts.
  assign req_ready = (state_q == RUN) && ((int'(cnt) < RSP_DEPTH) || pop);
  assign accept    = req_valid && req_ready;
  assign in_range  = (int'(req_addr) < DEPTH);
  assign old_word  = in_range ? mem[req_addr] : '0;

  // Per-byte merge: written bytes take new data, masked bytes keep old data,
  // out-of-range addresses read back as zero.
  for (genvar b = 0; b < NB; b++) begin : g_lane
    assign mrg_word[8*b +: 8] = !in_range   ? 8'h00 :
                                req_web[b]  ? old_word[8*b +: 8] :
                                              req_wdata[8*b +: 8];
  end

  // FSM state register.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) state_q <= CLEAR;
    else       state_q <= state_d;
  end

  // Next state: clear sweep ends on the last word; re-clear only when fully idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (clr_cnt == LAST) state_d = RUN;
      RUN:     if (clr_start && cnt == '0 && !accept) state_d = CLEAR;
      default: state_d = CLEAR;
    endcase
  end

  // Clear address counter; parked at zero outside CLEAR so a re-clear starts at 0.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN)                                   clr_cnt <= '0;
    else if (state_q == CLEAR && clr_cnt != LAST) clr_cnt <= clr_cnt + ADDR_W'(1);
    else                                         clr_cnt <= '0;
  end

  // Array write port: the clear sweep owns it in CLEAR, requests own it in RUN.
  // The merged word equals the old data on masked bytes, so a full-word write is exact.
  always_ff @(posedge CK) begin
    if (state_q == CLEAR)          mem[clr_cnt]  <= '0;
    else if (accept && in_range)   mem[req_addr] <= mrg_word;
  end

  // Outstanding credit count covers responses in the pipeline and in the FIFO.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) cnt <= '0;
    else begin
      case ({accept, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Read pipeline: the merged word is captured at the accept edge; a second
  // register stage adds one cycle when READ_LAT is 2.
  if (READ_LAT == 2) begin : g_lat2
    logic              vld_pipe;
    logic [DATA_W-1:0] dat_pipe;

    // Extra read stage between the array and the FIFO.
    always_ff @(posedge CK or negedge RSTN) begin
      if (!RSTN) begin
        vld_pipe <= 1'b0;
        dat_pipe <= '0;
      end else begin
        vld_pipe <= accept;
        if (accept) dat_pipe <= mrg_word;
      end
    end
    assign push_vld = vld_pipe;
    assign push_dat = dat_pipe;
  end else begin : g_lat1
    assign push_vld = accept;
    assign push_dat = mrg_word;
  end

  // FIFO storage; credits guarantee a free slot whenever push_vld is high.
  always_ff @(posedge CK) begin
    if (push_vld) fifo[wr_ptr] <= push_dat;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_vld) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)      rd_ptr <= ptr_inc(rd_ptr);
      case ({push_vld, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule
